rf_mode_ctrl: RTL

Mode/AUX sequencer for the RF transceiver, sitting between the external MCU pins (M0/M1 bus, AUX) and the transceiver controller. It synchronises and debounces an N-bit mode-pin bus and commits a new operating mode only when the datapath is idle. It drives AUX through boot, mode-switch and soft-reset delays, and issues a controller reset pulse on a reset command (0xC4 path). It generalises the transceiver's fixed 2-pin, unsynchronised mode wiring into a parametrised, handshaked block.

---
 rtl/rf_pkg.sv | 9 +
 rtl/sync_debounce.sv | 32 +++
 rtl/rf_mode_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared state, mode and command constants for the RF mode/AUX sequencer
package rf_pkg;
    typedef enum logic [2:0] {BOOT, IDLE, DRAIN, SWITCH, RST_HOLD} state_t;
    localparam logic [1:0] MODE_NORMAL    = 2'd0;
    localparam logic [1:0] MODE_WAKEUP    = 2'd1;
    localparam logic [1:0] MODE_POWERSAVE = 2'd2;
    localparam logic [1:0] MODE_CONFIG    = 2'd3;
    localparam logic [7:0] RESET_DETECT   = 8'hC4;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: per-bit pin synchroniser plus a stability counter measured against the committed mode
module sync_debounce #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2,
    parameter int COUNT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [WIDTH-1:0] mode_cur,
    output logic [WIDTH-1:0] pins_s,
    output logic             pending
);
    localparam int CW = $clog2(COUNT + 1);
    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0] db_cnt;
    assign pins_s  = sync_q[STAGES-1];
    assign pending = db_cnt == CW'(COUNT);
    // a change restarts the count; reaching the committed value cancels it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= '0;
            db_cnt <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pins_in};
            prev   <= pins_s;
            db_cnt <= (pins_s == mode_cur || pins_s != prev) ? '0 : pending ? db_cnt : db_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/rf_mode_ctrl.sv
// rf_mode_ctrl: commits debounced mode pins when idle, sequences AUX and the controller reset pulse
module rf_mode_ctrl
    import rf_pkg::*;
#(
    parameter int                    MODE_WIDTH          = 2,
    parameter int                    SYNC_STAGES         = 2,
    parameter int                    DEBOUNCE_CYCLES     = 16,
    parameter int                    BOOT_DELAY_CYCLES   = 1000,
    parameter int                    SWITCH_DELAY_CYCLES = 100,
    parameter int                    RESET_HOLD_CYCLES   = 4,
    parameter logic [MODE_WIDTH-1:0] MODE_RESET_VAL      = MODE_WIDTH'(MODE_NORMAL)
) (
    input  logic                  internal_clk,
    input  logic                  rst,
    input  logic [MODE_WIDTH-1:0] mode_pins_in,
    input  logic                  busy_in,
    input  logic                  soft_reset_req,
    output logic [MODE_WIDTH-1:0] mode_out,
    output logic                  mode_change,
    output logic                  AUX,
    output logic                  ctrl_rst
);
    localparam int MAX_BS    = BOOT_DELAY_CYCLES > SWITCH_DELAY_CYCLES ? BOOT_DELAY_CYCLES : SWITCH_DELAY_CYCLES;
    localparam int MAX_DELAY = MAX_BS > RESET_HOLD_CYCLES ? MAX_BS : RESET_HOLD_CYCLES;
    localparam int CW        = $clog2(MAX_DELAY + 1);
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] SW_LAST   = CW'(SWITCH_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYCLES - 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic [MODE_WIDTH-1:0] pins_s;
    logic pending;
    sync_debounce #(
        .WIDTH (MODE_WIDTH),
        .STAGES(SYNC_STAGES),
        .COUNT (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk     (internal_clk),
        .rst     (rst),
        .pins_in (mode_pins_in),
        .mode_cur(mode_out),
        .pins_s  (pins_s),
        .pending (pending)
    );
    always_ff @(posedge internal_clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            cnt         <= '0;
            mode_out    <= MODE_RESET_VAL;
            mode_change <= 1'b0;
            AUX         <= 1'b0;
            ctrl_rst    <= 1'b0;
        end else begin
            mode_change <= 1'b0;
            if (soft_reset_req) begin
                state    <= RST_HOLD;
                cnt      <= '0;
                ctrl_rst <= 1'b1;
                AUX      <= 1'b0;
            end else begin
                case (state)
                    BOOT: begin
                        if (cnt == BOOT_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else cnt <= cnt + 1'b1;
                    end
                    // DRAIN falls back to IDLE when the pins revert before busy clears
                    IDLE, DRAIN: begin
                        cnt <= '0;
                        if (pending && !busy_in) begin
                            state       <= SWITCH;
                            mode_out    <= pins_s;
                            mode_change <= 1'b1;
                            AUX         <= 1'b0;
                        end else if (pending) begin
                            state <= DRAIN;
                            AUX   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            AUX   <= !busy_in;
                        end
                    end
                    SWITCH: begin
                        if (cnt == SW_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            AUX   <= !busy_in;
                        end else cnt <= cnt + 1'b1;
                    end
                    RST_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            state    <= BOOT;
                            cnt      <= '0;
                            ctrl_rst <= 1'b0;
                        end else cnt <= cnt + 1'b1;
                    end
                    default: begin
                        state <= BOOT;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule
